vga_mem_arbiter: RTL and testbench

- Arbitrates a single-port synchronous frame memory (1-cycle read latency) between two requesters:
  - the display pixel fetch path (read-only, feeding the colour generator);
  - the ASIP processor's video-memory port (read/write).
- Display reads have priority. A starvation counter guarantees the processor forward progress.
- Sits between the VGA timing/colour path and the processor bus, inside the vga top-level.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/starve_counter.sv | 37 +++
 rtl/vga_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA block: default frame-memory geometry and
// the arbiter state/grant encodings.
package vga_pkg;

    localparam int unsigned VgaAw = 16;
    localparam int unsigned VgaDw = 8;

    typedef enum logic [0:0] {
        Arb,
        CpuAck
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnDisp,
        OwnCpu
    } grant_e;

    // Bits needed to hold 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive cycles a requester has been refused.
// Clear wins over increment.
module starve_counter
    import vga_pkg::*;
#(
    parameter int unsigned MAX = 64,
    localparam int unsigned W = cnt_width(MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame-memory arbiter: display reads take priority, the CPU is
// guaranteed a slot by a starvation counter and owns the bus during blanking.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned AW         = VgaAw,
    parameter int unsigned DW         = VgaDw,
    parameter int unsigned STARVE_MAX = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blank_b,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    output logic          disp_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    grant_e        grant;
    logic          starve_at_max;
    logic          starve_inc;
    logic          starve_clr;

    logic          disp_valid_q;
    logic          disp_miss_q;
    logic          cpu_ack_q;
    logic          cpu_rd_q;
    logic [DW-1:0] disp_hold_q;
    logic [DW-1:0] cpu_hold_q;

    always_comb begin
        state_d = state_q;
        grant   = OwnNone;
        unique case (state_q)
            Arb: begin
                if (cpu_req && (starve_at_max || !blank_b)) begin
                    grant = OwnCpu;
                end else if (disp_req) begin
                    grant = OwnDisp;
                end else if (cpu_req) begin
                    grant = OwnCpu;
                end
                if (grant == OwnCpu) begin
                    state_d = CpuAck;
                end
            end
            // The CPU request is still up here (ack not yet seen by the CPU).
            CpuAck: begin
                if (disp_req) begin
                    grant = OwnDisp;
                end
                state_d = Arb;
            end
            default: state_d = Arb;
        endcase
    end

    assign starve_inc = (state_q == Arb) && cpu_req && (grant != OwnCpu);
    assign starve_clr = (grant == OwnCpu) || !cpu_req;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clear  (starve_clr),
        .at_max (starve_at_max)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (grant)
            OwnDisp: begin
                mem_addr = disp_addr;
            end
            OwnCpu: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= Arb;
            disp_valid_q <= 1'b0;
            disp_miss_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rd_q     <= 1'b0;
            disp_hold_q  <= '0;
            cpu_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            disp_valid_q <= (grant == OwnDisp);
            disp_miss_q  <= disp_req && (grant != OwnDisp);
            cpu_ack_q    <= (grant == OwnCpu);
            cpu_rd_q     <= (grant == OwnCpu) && !cpu_we;
            if (disp_valid_q) begin
                disp_hold_q <= mem_rdata;
            end
            if (cpu_rd_q) begin
                cpu_hold_q <= mem_rdata;
            end
        end
    end

    // Memory data arrives in the return cycle, so it is steered straight out
    // then and held in the local register afterwards.
    assign disp_valid = disp_valid_q;
    assign disp_miss  = disp_miss_q;
    assign disp_data  = disp_valid_q ? mem_rdata : disp_hold_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rd_q ? mem_rdata : cpu_hold_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: reset, grant table, multi-cycle
// corner sequences and a randomised run against a reference memory.
module tb_vga_mem_arbiter;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        blank_b;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_miss;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    vga_mem_arbiter #(
        .AW         (16),
        .DW         (8),
        .STARVE_MAX (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .blank_b    (blank_b),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_miss  (disp_miss),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous single-port frame memory, 1-cycle read latency.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic blank_b;
        logic disp_req;
        logic cpu_req;
        logic cpu_we;
        int   sel;      // 0 none, 1 display, 2 cpu
        logic valid;
        logic miss;
        logic ack;
    } vec_t;

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
    } dexp_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cexp_t;

    dexp_t disp_q[$];
    cexp_t cpu_q[$];

    int   checks = 0;
    int   failures = 0;
    int   disp_reads = 0;
    int   issued = 0;
    int   acked = 0;
    int   wait_cnt = 0;
    logic busy = 1'b0;
    logic prev_ack = 1'b0;
    logic [7:0] exp_rd;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] + 8'h10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic disp_check();
        dexp_t e;
        if (disp_q.size() == 0) return;
        e = disp_q.pop_front();
        if (e.req) begin
            chk("disp_valid_xor_miss", 32'(disp_valid ^ disp_miss), 32'd1);
            if (disp_valid) begin
                chk("disp_data", 32'(disp_data), 32'(ref_mem[e.addr]));
                disp_reads++;
            end
        end else begin
            chk("disp_idle_valid", 32'(disp_valid), 32'd0);
            chk("disp_idle_miss", 32'(disp_miss), 32'd0);
        end
    endtask

    task automatic cpu_monitor();
        cexp_t e;
        if (cpu_ack) begin
            chk("cpu_ack_spacing", 32'(prev_ack), 32'd0);
            chk("cpu_ack_outstanding", 32'(cpu_q.size()), 32'd1);
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                acked++;
                if (!e.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[e.addr]));
                else ref_mem[e.addr] = e.wdata;
            end
            busy    = 1'b0;
            cpu_req = 1'b0;
        end
        prev_ack = cpu_ack;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = pat(16'(i));
            ref_mem[i] = pat(16'(i));
        end

        reset = 1'b1; blank_b = 1'b1; disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        exp_rd = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_disp_miss", 32'(disp_miss), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_state", 32'(dut.state_q), 32'(Arb));
        reset = 1'b0;

        // Reset landing in the CPU_ACK cycle drops the pending ack
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0033;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rmid_cpu_ack", 32'(cpu_ack), 0);
        chk("rmid_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rmid_disp_valid", 32'(disp_valid), 0);
        chk("rmid_disp_miss", 32'(disp_miss), 0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_ack_after", 32'(cpu_ack), 0);
        chk("rmid_state_arb", 32'(dut.state_q), 32'(Arb));
        chk("rmid_starve_zero", 32'(dut.u_starve.cnt_q), 0);
        cpu_req = 1'b1;
        @(negedge clk);
        chk("rmid_reissue_ack", 32'(cpu_ack), 1);
        chk("rmid_reissue_rdata", 32'(cpu_rdata), 32'(pat(16'h0033)));
        exp_rd = pat(16'h0033);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rmid_ack_pulse", 32'(cpu_ack), 0);

        // Grant table: one request pattern per row, each from ARB
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            blank_b   = vecs[i].blank_b;
            disp_req  = vecs[i].disp_req;
            cpu_req   = vecs[i].cpu_req;
            cpu_we    = vecs[i].cpu_we;
            disp_addr = 16'h0100 + 16'(i);
            cpu_addr  = 16'h0200 + 16'(i);
            cpu_wdata = 8'h40 + 8'(i);
            #1;
            case (vecs[i].sel)
                1:       chk("tbl_mem_addr", 32'(mem_addr), 32'(disp_addr));
                2:       chk("tbl_mem_addr", 32'(mem_addr), 32'(cpu_addr));
                default: chk("tbl_mem_addr", 32'(mem_addr), 0);
            endcase
            chk("tbl_mem_we", 32'(mem_we), 32'(vecs[i].sel == 2 && vecs[i].cpu_we));
            if (vecs[i].sel == 2 && vecs[i].cpu_we) begin
                chk("tbl_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
                ref_mem[cpu_addr] = cpu_wdata;
            end
            if (vecs[i].sel == 2 && !vecs[i].cpu_we) exp_rd = pat(cpu_addr);
            @(negedge clk);
            chk("tbl_disp_valid", 32'(disp_valid), 32'(vecs[i].valid));
            chk("tbl_disp_miss", 32'(disp_miss), 32'(vecs[i].miss));
            chk("tbl_cpu_ack", 32'(cpu_ack), 32'(vecs[i].ack));
            if (vecs[i].valid) chk("tbl_disp_data", 32'(disp_data), 32'(pat(disp_addr)));
            if (vecs[i].ack) chk("tbl_cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
            disp_req = 1'b0; cpu_req = 1'b0; blank_b = 1'b1;
        end

        // Display only, addresses 0..7 back to back
        begin
            int r0;
            r0 = disp_reads;
            for (int i = 0; i <= 8; i++) begin
                @(negedge clk);
                disp_check();
                disp_req  = (i < 8);
                disp_addr = 16'(i);
                disp_q.push_back({disp_req, disp_addr});
            end
            @(negedge clk);
            disp_check();
            chk("disp_only_count", 32'(disp_reads - r0), 8);
        end

        // CPU write then an immediate read attempt: second access needs 2 cycles
        @(negedge clk);
        disp_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h0123; cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("wr_ack", 32'(cpu_ack), 1);
        chk("wr_rdata_hold", 32'(cpu_rdata), 32'(exp_rd));
        ref_mem[16'h0123] = 8'hA5;
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_no_back_to_back", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("rd_ack", 32'(cpu_ack), 1);
        chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
        exp_rd = 8'hA5;
        cpu_req = 1'b0;
        @(negedge clk);

        // Starvation: display hogs the bus, CPU must win on cycle 65
        begin
            int   grant_cyc;
            int   miss_cnt;
            logic done;
            grant_cyc = 0; miss_cnt = 0; done = 1'b0;
            blank_b = 1'b1; disp_req = 1'b1; disp_addr = 16'h0005;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077;
            for (int k = 2; k <= 100; k++) begin
                @(negedge clk);
                if (k == 65) chk("starve_cnt_64", 32'(dut.u_starve.cnt_q), 64);
                if (disp_miss) miss_cnt++;
                if (cpu_ack && !done) begin
                    grant_cyc = k - 1;
                    done = 1'b1;
                    chk("starve_rdata", 32'(cpu_rdata), 32'(pat(16'h0077)));
                    chk("starve_cnt_clear", 32'(dut.u_starve.cnt_q), 0);
                    chk("starve_miss_at_grant", 32'(disp_miss), 1);
                    cpu_req = 1'b0;
                end else if (done) begin
                    chk("starve_disp_resumes", 32'(disp_valid), 1);
                    break;
                end
            end
            disp_req = 1'b0;
            exp_rd = pat(16'h0077);
            chk("starve_grant_cycle", 32'(grant_cyc), 65);
            chk("starve_miss_count", 32'(miss_cnt), 1);
        end
        @(negedge clk);

        // Blanking: CPU first, display in the CPU_ACK slot
        @(negedge clk);
        blank_b = 1'b0; disp_req = 1'b1; disp_addr = 16'h0009;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
        @(negedge clk);
        chk("blank_cpu_ack", 32'(cpu_ack), 1);
        chk("blank_miss", 32'(disp_miss), 1);
        chk("blank_valid0", 32'(disp_valid), 0);
        chk("blank_rdata", 32'(cpu_rdata), 32'(pat(16'h0011)));
        cpu_req = 1'b0;
        @(negedge clk);
        chk("blank_disp_valid", 32'(disp_valid), 1);
        chk("blank_disp_data", 32'(disp_data), 32'(pat(16'h0009)));
        chk("blank_miss_once", 32'(disp_miss), 0);
        chk("blank_ack_pulse", 32'(cpu_ack), 0);
        disp_req = 1'b0; blank_b = 1'b1;
        @(negedge clk);
        chk("blank_idle_valid", 32'(disp_valid), 0);
        chk("blank_idle_miss", 32'(disp_miss), 0);

        // Random interleaving against the reference memory
        disp_reads = 0;
        prev_ack   = 1'b0;
        for (int cyc = 0; cyc < 6000 && disp_reads < 1000; cyc++) begin
            @(negedge clk);
            disp_check();
            cpu_monitor();
            if (busy) begin
                wait_cnt++;
                if (wait_cnt > 200) begin
                    chk("cpu_wait_bound", 32'(wait_cnt), 200);
                    busy = 1'b0; cpu_req = 1'b0; cpu_q.delete();
                end
            end else if (!cpu_ack && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 255));
                cpu_wdata = 8'($urandom_range(0, 255));
                cpu_q.push_back({cpu_we, cpu_addr, cpu_wdata});
                issued++;
                busy = 1'b1;
                wait_cnt = 0;
            end
            disp_req  = ($urandom_range(0, 9) < 7);
            disp_addr = 16'($urandom_range(0, 255));
            blank_b   = ($urandom_range(0, 7) != 0);
            disp_q.push_back({disp_req, disp_addr});
        end
        disp_req = 1'b0;
        for (int k = 0; k < 300 && (busy || disp_q.size() != 0); k++) begin
            @(negedge clk);
            disp_check();
            cpu_monitor();
            if (busy) disp_q.push_back({1'b0, 16'h0000});
        end
        chk("cpu_drained", 32'(busy), 0);
        chk("cpu_ack_count", 32'(acked), 32'(issued));
        chk("disp_reads_1000", 32'(disp_reads >= 1000), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
